universal_shift_register: RTL
=============================

Name: universal_shift_register

Overview:
- Parametrised WIDTH-bit register with eight operating modes: hold, shift left/right, rotate left/right, parallel load, synchronous clear, invert.
- Built from rising-edge, asynchronously reset storage stages.
- Also tracks how many shift/rotate steps have occurred since the last load or clear.
- Generic datapath building block for serial/parallel converters and counters in the lab designs.

Parameters:
WIDTH, 8, register width in bits; legal range 2..32.
RESET_VALUE, '0, value of o_q after async reset and after the CLEAR mode; WIDTH bits.

Ports:
i_clk  input  1  clock; all state updates on rising edge.
i_rst_n  input  1  asynchronous active-low reset.
i_mode  input  3  operation select; encoding below.
i_ser_l  input  1  serial input entering at the MSB on SHR.
i_ser_r  input  1  serial input entering at the LSB on SHL.
i_d  input  WIDTH  parallel load data.
o_q  output  WIDTH  register contents.
o_qn  output  WIDTH  bitwise inverse of o_q.
o_ser_l  output  1  equals o_q[WIDTH-1]; bit shifted out on SHL.
o_ser_r  output  1  equals o_q[0]; bit shifted out on SHR.
o_shift_cnt  output  $clog2(WIDTH+1)  shift/rotate steps since last LOAD/CLEAR/reset; saturates at WIDTH.
o_full_shift  output  1  high when o_shift_cnt == WIDTH.

Behaviour:
- Reset (i_rst_n low, asynchronous, no clock needed):
  - o_q = RESET_VALUE, o_qn = ~RESET_VALUE.
  - o_shift_cnt = 0, o_full_shift = 0.
  - Held while low; normal operation resumes at the first rising edge after deassertion.
- Mode encoding and next state on the rising edge:
  - 000 HOLD: q unchanged.
  - 001 SHL: q <= {q[WIDTH-2:0], i_ser_r}.
  - 010 SHR: q <= {i_ser_l, q[WIDTH-1:1]}.
  - 011 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 100 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 101 LOAD: q <= i_d.
  - 110 CLEAR: q <= RESET_VALUE (synchronous).
  - 111 INVERT: q <= ~q.
- Latency: one cycle from mode/data sampling to o_q. o_qn, o_ser_l, o_ser_r and o_full_shift are combinational from registered state and never glitch-dependent on inputs.
- Shift counter:
  - LOAD or CLEAR: next count = 0.
  - SHL/SHR/ROL/ROR: count + 1, saturating at WIDTH (stays WIDTH, no wrap).
  - HOLD/INVERT: count unchanged.
- Boundary conditions:
  - After WIDTH consecutive ROL or ROR, q returns to its starting value and o_full_shift = 1.
  - After WIDTH consecutive SHL with constant i_ser_r, q is all i_ser_r.
  - Reset asserted mid-operation overrides any mode immediately; the count clears with it.
  - Serial inputs are ignored in every mode except SHL (i_ser_r) and SHR (i_ser_l).
  - i_d is ignored except in LOAD.
  - X on i_mode is not required to be handled; the bench drives legal values only.

Decomposition:
- Package usr_pkg:
  - Enum typedef usr_mode_e for the eight 3-bit mode encodings (HOLD, SHL, SHR, ROL, ROR, LOAD, CLEAR, INVERT).
  - Function for the counter width, $clog2(WIDTH+1).
- Sub-module d_flip_flop_ar: single-bit rising-edge storage stage with asynchronous active-low reset and a reset-value input.
  - Instantiated WIDTH times (generate loop) for q.
  - Instantiated once per bit of the shift counter.
  - Next-state mux lives in universal_shift_register.

Test Plan:
1. WIDTH=8, RESET_VALUE=8'hA5; pulse i_rst_n low between clock edges -> o_q=8'hA5 immediately, o_qn=8'h5A, o_shift_cnt=0, before any clock edge.
2. LOAD i_d=8'h81, then 8x ROL -> o_q sequence 03,06,0C,18,30,60,C0,81; o_shift_cnt 1..8; o_full_shift=1 after the 8th edge.
3. LOAD 8'hF0, SHR x3 with i_ser_l=0 -> 8'h78, 8'h3C, 8'h1E; o_ser_r after the 3rd edge = 0.
4. LOAD 8'h00, SHL x10 with i_ser_r=1 -> o_q=8'hFF after the 8th edge; o_shift_cnt stays 8 on edges 9 and 10 (saturation).
5. LOAD 8'h3C, INVERT -> 8'hC3, o_shift_cnt=0; CLEAR -> 8'hA5, count 0; HOLD x5 with toggling i_d/i_ser -> o_q stays 8'hA5.
6. Mid-sequence reset: LOAD 8'h12, ROR x2, assert i_rst_n low while i_mode=SHL -> o_q=8'hA5, count 0 asynchronously; after release, the next SHL edge gives 8'h4A|i_ser_r and count 1.

Source files
------------

// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode encodings and
// the shift-counter width helper.
package usr_pkg;

  // Operation select; the encoding is fixed by the i_mode port.
  typedef enum logic [2:0] {
    MODE_HOLD   = 3'b000,
    MODE_SHL    = 3'b001,
    MODE_SHR    = 3'b010,
    MODE_ROL    = 3'b011,
    MODE_ROR    = 3'b100,
    MODE_LOAD   = 3'b101,
    MODE_CLEAR  = 3'b110,
    MODE_INVERT = 3'b111
  } usr_mode_e;

  // Bits needed to hold a step count in 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/d_flip_flop_ar.sv
// Single-bit rising-edge storage stage with asynchronous active-low reset.
// The reset value is an input so one cell serves both 0- and 1-reset bits.
module d_flip_flop_ar (
  input  logic clk,
  input  logic rst_n,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  // Capture d on the rising edge; reset forces rst_val without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= rst_val;
    else        q <= d;
  end

endmodule

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift, rotate, load, clear and
// invert, plus a saturating count of shift/rotate steps since the last
// load, clear or reset. All state lives in d_flip_flop_ar cells; this module
// only builds the next-state muxes and the derived outputs.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [2:0]                    i_mode,
  input  logic                          i_ser_l,
  input  logic                          i_ser_r,
  input  logic [WIDTH-1:0]              i_d,
  output logic [WIDTH-1:0]              o_q,
  output logic [WIDTH-1:0]              o_qn,
  output logic                          o_ser_l,
  output logic                          o_ser_r,
  output logic [cnt_width(WIDTH)-1:0]   o_shift_cnt,
  output logic                          o_full_shift
);

  localparam int            CW      = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  // Shift slicing below assumes at least two bits; catch bad widths early.
  if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
    $error("universal_shift_register: WIDTH must be in 2..32");
  end

  usr_mode_e         mode;
  logic [WIDTH-1:0]  q;
  logic [WIDTH-1:0]  q_nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;

  assign mode = usr_mode_e'(i_mode);

  // Data next-state mux: serial inputs and i_d only matter in their own modes.
  always_comb begin
    q_nxt = q;
    case (mode)
      MODE_HOLD:   q_nxt = q;
      MODE_SHL:    q_nxt = {q[WIDTH-2:0], i_ser_r};
      MODE_SHR:    q_nxt = {i_ser_l, q[WIDTH-1:1]};
      MODE_ROL:    q_nxt = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:    q_nxt = {q[0], q[WIDTH-1:1]};
      MODE_LOAD:   q_nxt = i_d;
      MODE_CLEAR:  q_nxt = RESET_VALUE;
      MODE_INVERT: q_nxt = ~q;
      default:     q_nxt = q;
    endcase
  end

  // Step counter next state: restart on load/clear, saturate at WIDTH on moves.
  always_comb begin
    cnt_nxt = cnt;
    case (mode)
      MODE_LOAD, MODE_CLEAR: cnt_nxt = '0;
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR: begin
        if (cnt != CNT_MAX) cnt_nxt = cnt + CW'(1);
      end
      default: cnt_nxt = cnt;
    endcase
  end

  // Data storage: one cell per bit, each resetting to its RESET_VALUE bit.
  for (genvar i = 0; i < WIDTH; i++) begin : g_q
    d_flip_flop_ar u_q_ff (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .rst_val (RESET_VALUE[i]),
      .d       (q_nxt[i]),
      .q       (q[i])
    );
  end

  // Counter storage: one cell per bit, always resetting to zero.
  for (genvar j = 0; j < CW; j++) begin : g_cnt
    d_flip_flop_ar u_cnt_ff (
      .clk     (i_clk),
      .rst_n   (i_rst_n),
      .rst_val (1'b0),
      .d       (cnt_nxt[j]),
      .q       (cnt[j])
    );
  end

  // Derived outputs depend on registered state only.
  assign o_q          = q;
  assign o_qn         = ~q;
  assign o_ser_l      = q[WIDTH-1];
  assign o_ser_r      = q[0];
  assign o_shift_cnt  = cnt;
  assign o_full_shift = (cnt == CNT_MAX);

endmodule
